reg_bus_reader: RTL

REG_BUS_READER -- requirements
Module: reg_bus_reader

---
 rtl/reg_bus_if.sv | 30 +++
 rtl/reg_bus_reader.sv | 126 ++++++++++++
 2 files changed

// File: rtl/reg_bus_if.sv
// Handshake and register-bus bundle for reg_bus_reader.
// master = reader side, slave = requester/consumer and register bank.
interface reg_bus_if #(
    parameter int NrOfBits = 32,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2
) ();
    logic                Tick;
    logic                ReqValid;
    logic                ReqScan;
    logic [AddrBits-1:0] ReqAddr;
    logic                ReqReady;
    logic [NrOfBits-1:0] BusIn;
    logic [NrOfRegs-1:0] cs;
    logic                RspValid;
    logic [NrOfBits-1:0] RspData;
    logic [AddrBits-1:0] RspAddr;
    logic                RspLast;
    logic                RspReady;

    modport master (
        input  Tick, ReqValid, ReqScan, ReqAddr, BusIn, RspReady,
        output ReqReady, cs, RspValid, RspData, RspAddr, RspLast
    );

    modport slave (
        output Tick, ReqValid, ReqScan, ReqAddr, BusIn, RspReady,
        input  ReqReady, cs, RspValid, RspData, RspAddr, RspLast
    );
endinterface

// File: rtl/reg_bus_reader.sv
// Sequential reader for a shared tri-state register bus.
// Selects one register at a time, waits for settle, captures, responds.
module reg_bus_reader #(
    parameter int NrOfBits    = 32,
    parameter int NrOfRegs    = 4,
    parameter int AddrBits    = 2,
    parameter int SettleTicks = 1
) (
    input  logic     Clock,
    input  logic     Reset,
    reg_bus_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, GAP, SELECT, CAPTURE, RESP
    } state_t;

    localparam logic [AddrBits:0] LastIdx = (AddrBits+1)'(NrOfRegs - 1);
    localparam logic [3:0] SettleInit = 4'(SettleTicks);

    state_t              state_q;
    state_t              state_d;
    logic [AddrBits-1:0] cur_q;
    logic                scan_q;
    logic                oor_q;
    logic [3:0]          cnt_q;
    logic [NrOfBits-1:0] data_q;
    logic [AddrBits-1:0] raddr_q;
    logic                last_q;
    logic                rdy_en_q;

    logic                req_ready;
    logic                rsp_valid;
    logic [NrOfRegs-1:0] cs_d;
    logic                accept;
    logic                rsp_take;
    logic                req_oor;
    logic                at_last;
    logic                settle_done;

    assign req_oor     = {1'b0, bus.ReqAddr} > LastIdx;
    assign at_last     = {1'b0, cur_q} == LastIdx;
    assign accept      = bus.ReqValid && req_ready;
    assign rsp_take    = rsp_valid && bus.RspReady;
    assign settle_done = (cnt_q == 4'd0) || (bus.Tick && cnt_q == 4'd1);

    // State register; reset lands in IDLE with the bus released.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: only the settle wait in SELECT depends on Tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = GAP;
            GAP:     state_d = SELECT;
            SELECT:  if (settle_done) state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_take) state_d = last_q ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: at most one select low, only in SELECT/CAPTURE.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        cs_d      = '1;
        unique case (state_q)
            IDLE: req_ready = rdy_en_q;
            SELECT, CAPTURE: begin
                for (int i = 0; i < NrOfRegs; i++) begin
                    if (!oor_q && cur_q == AddrBits'(i)) cs_d[i] = 1'b0;
                end
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: request latch, settle counter, response capture.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdy_en_q <= 1'b0;
            cur_q    <= '0;
            scan_q   <= 1'b0;
            oor_q    <= 1'b0;
            cnt_q    <= 4'd0;
            data_q   <= '0;
            raddr_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_q  <= bus.ReqAddr;
                        scan_q <= bus.ReqScan && !req_oor;
                        oor_q  <= req_oor;
                    end
                end
                GAP: cnt_q <= SettleInit;
                SELECT: begin
                    if (bus.Tick && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                CAPTURE: begin
                    data_q  <= oor_q ? '0 : bus.BusIn;
                    raddr_q <= cur_q;
                    last_q  <= !scan_q || at_last;
                end
                RESP: begin
                    if (rsp_take && !last_q) cur_q <= cur_q + AddrBits'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ReqReady = req_ready;
    assign bus.cs       = cs_d;
    assign bus.RspValid = rsp_valid;
    assign bus.RspData  = data_q;
    assign bus.RspAddr  = raddr_q;
    assign bus.RspLast  = last_q;
endmodule
